// File: rtl/spu_pkg.sv
// rtl/spu_pkg.sv - shared frame-buffer geometry, requester indices and arbiter state encoding
//
// Purpose : constants shared by the sprite/pixel unit blocks.
// Contents: frame geometry (FB_WIDTH, FB_HEIGHT, FB_DEPTH), frame RAM widths
//           (FB_ADDR_W, PIXEL_W), draw-engine requester indices and the
//           write-arbiter FSM state type.
package spu_pkg;

   localparam int FB_WIDTH  = 320;
   localparam int FB_HEIGHT = 240;
   localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;

   localparam int FB_ADDR_W = 17;
   localparam int PIXEL_W   = 24;

   localparam int REQ_MAP    = 0;
   localparam int REQ_SPRITE = 1;
   localparam int REQ_SCORE  = 2;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_t;

endpackage

// File: rtl/fb_wr_arbiter_rr_pick.sv
// rtl/fb_wr_arbiter_rr_pick.sv - combinational round-robin priority encoder
//
// Purpose: finds the first set bit of req searching upward from ptr with
//          wrap-around (ptr, ptr+1, ..., N-1, 0, ...).
// Ports  : req [N]      request vector
//          ptr [IDX_W]  search start index, must be < N
//          any          at least one request is set
//          idx [IDX_W]  winning index (0 when any is low)
module rr_pick #(
   parameter int N     = 3,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] idx
);

   logic [2*N-1:0] rot;
   int             sum;

   // Doubling the vector and shifting by ptr turns the wrap-around search
   // into a plain lowest-set-bit search over rot[N-1:0].
   always_comb begin
      rot = {req, req} >> ptr;
      any = 1'b0;
      idx = '0;
      sum = 0;
      // Walk downward so the smallest offset from ptr is the last to write.
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            sum = int'(ptr) + k;
            if (sum >= N) begin
               sum = sum - N;
            end
            any = 1'b1;
            idx = IDX_W'(sum);
         end
      end
   end

endmodule

// File: rtl/fb_wr_arbiter.sv
// rtl/fb_wr_arbiter.sv - round-robin arbiter for the frame-buffer write port
//
// Purpose: shares frame RAM port A between the map, sprite and score draw
//          engines. One requester is granted at a time and keeps the grant
//          until its burst ends or MAX_BURST beats have been taken. Writes
//          outside the frame are dropped and counted.
// Ports  : clk, rst                     clock, synchronous active-high reset
//          req_valid/req_last [NUM_REQ] per-requester valid and burst end
//          req_addr/req_data            packed, requester i at [i*W +: W]
//          req_ready [NUM_REQ]          per-requester accept
//          fb_we/fb_addr/fb_data        registered frame RAM write
//          grant_id                     current or last granted requester
//          busy                         high while a grant is held
//          oob_cnt                      saturating count of dropped writes
module fb_wr_arbiter
   import spu_pkg::*;
#(
   parameter int NUM_REQ   = 3,
   parameter int ADDR_W    = spu_pkg::FB_ADDR_W,
   parameter int DATA_W    = spu_pkg::PIXEL_W,
   parameter int FB_DEPTH  = spu_pkg::FB_DEPTH,
   parameter int MAX_BURST = 256
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ-1:0]          req_last,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        fb_we,
   output logic [ADDR_W-1:0]           fb_addr,
   output logic [DATA_W-1:0]           fb_data,
   output logic [1:0]                  grant_id,
   output logic                        busy,
   output logic [15:0]                 oob_cnt
);

   localparam int GID_W  = 2;
   localparam int BCNT_W = $clog2(MAX_BURST) + 1;

   localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(FB_DEPTH);
   localparam logic [BCNT_W-1:0] CAP_LAST  = BCNT_W'(MAX_BURST - 1);
   localparam logic [GID_W-1:0]  LAST_ID   = GID_W'(NUM_REQ - 1);

   arb_state_t          state;
   arb_state_t          state_nxt;
   logic [GID_W-1:0]    rr_ptr;
   logic [BCNT_W-1:0]   burst_cnt;

   logic                pick_any;
   logic [GID_W-1:0]    pick_idx;

   logic                g_valid;
   logic                g_last;
   logic [ADDR_W-1:0]   g_addr;
   logic [DATA_W-1:0]   g_data;
   logic                beat;
   logic                cap_hit;
   logic                rel;
   logic                in_range;

   rr_pick #(
      .N     (NUM_REQ),
      .IDX_W (GID_W)
   ) u_rr_pick (
      .req (req_valid),
      .ptr (rr_ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   // Select the granted requester's stream.
   always_comb begin
      g_valid = 1'b0;
      g_last  = 1'b0;
      g_addr  = '0;
      g_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == GID_W'(i)) begin
            g_valid = req_valid[i];
            g_last  = req_last[i];
            g_addr  = req_addr[i*ADDR_W +: ADDR_W];
            g_data  = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign beat     = (state == ST_GRANT) && g_valid;
   assign cap_hit  = (burst_cnt == CAP_LAST);
   assign rel      = beat && (g_last || cap_hit);
   assign in_range = (g_addr < DEPTH_LIM);

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (pick_any) state_nxt = ST_GRANT;
         ST_GRANT: if (rel)      state_nxt = ST_IDLE;
         default:                state_nxt = ST_IDLE;
      endcase
   end

   // FSM: outputs. Ready depends on registered state only, so there is no
   // combinational path from req_valid back to req_ready.
   always_comb begin
      busy      = (state == ST_GRANT);
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = busy && (grant_id == GID_W'(i));
      end
   end

   // Grant bookkeeping and the registered RAM write.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr    <= '0;
         grant_id  <= '0;
         burst_cnt <= '0;
         fb_we     <= 1'b0;
         fb_addr   <= '0;
         fb_data   <= '0;
         oob_cnt   <= '0;
      end else begin
         fb_we <= 1'b0;

         if ((state == ST_IDLE) && pick_any) begin
            grant_id  <= pick_idx;
            burst_cnt <= '0;
         end

         if (beat) begin
            fb_addr   <= g_addr;
            fb_data   <= g_data;
            fb_we     <= in_range;
            burst_cnt <= burst_cnt + 1'b1;
            if (!in_range && (oob_cnt != 16'hFFFF)) begin
               oob_cnt <= oob_cnt + 16'd1;
            end
         end

         if (rel) begin
            rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
         end
      end
   end

endmodule

// File: doc/fb_wr_arbiter.md
Name: fb_wr_arbiter

Overview:
Shares the single frame-buffer write port (port A of the dual-port frame RAM) between the draw engines: map, sprite and score. Each engine presents a valid/ready write stream with a burst-end marker. The block grants one requester at a time, round-robin, and holds the grant until the burst ends or a burst-length cap is hit. It drives a registered we/addr/data to the RAM and drops any write outside the 320x240 frame.

Parameters:
NUM_REQ, 3, number of requesters (index 0 = map, 1 = sprite, 2 = score)
ADDR_W, 17, frame-buffer address width
DATA_W, 24, pixel width (RGB888)
FB_DEPTH, 76800, valid addresses are 0..FB_DEPTH-1
MAX_BURST, 256, maximum beats per grant before forced release

Ports:
clk  in  1  100 MHz system clock (buffered DCM output)
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester write valid
req_last  in  NUM_REQ  final beat of the requester's burst
req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  packed pixel data, same packing as req_addr
req_ready  out  NUM_REQ  per-requester accept
fb_we  out  1  frame RAM write enable
fb_addr  out  ADDR_W  frame RAM address
fb_data  out  DATA_W  frame RAM data
grant_id  out  2  index of current or last granted requester
busy  out  1  high while in GRANT
oob_cnt  out  16  count of dropped out-of-range writes, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0, fb_we=0, fb_addr=0, fb_data=0, oob_cnt=0, req_ready=0, busy=0.
- IDLE:
  - If any req_valid is high, pick the first set bit searching upward from rr_ptr with wrap-around (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
  - Register the winner into grant_id, clear burst_cnt, move to GRANT.
  - No requester is ready while in IDLE.
- GRANT:
  - req_ready[i] = (i == grant_id). This is combinational from registered state only, with no path from req_valid.
  - A beat transfers when req_valid[g] and req_ready[g] are both high.
- On a beat:
  - fb_addr <= addr[g] and fb_data <= data[g].
  - fb_we <= (addr[g] < FB_DEPTH).
  - If addr[g] >= FB_DEPTH, fb_we stays 0 and oob_cnt increments, holding at 16'hFFFF once reached.
  - burst_cnt increments.
- Write latency: exactly 1 cycle from the handshake edge to fb_we.
- Without a beat: fb_we <= 0. fb_addr and fb_data hold their values.
- Grant release: a beat with req_last[g]=1, or a beat where burst_cnt == MAX_BURST-1, returns the FSM to IDLE and sets rr_ptr <= (g+1) mod NUM_REQ.
- Valid drop during GRANT: if valid[g] goes low while granted, the grant is kept (the requester may stall). There is no timeout.
- Re-arbitration cost: one IDLE bubble cycle between bursts. Peak throughput is therefore MAX_BURST/(MAX_BURST+1).
- busy = (state == GRANT).
- Reset mid-burst: the FSM returns to IDLE immediately, fb_we is 0 on the next cycle, and the partial burst is abandoned with no completion signalled. Requesters are reset by the same rst.
- Simultaneous requests with rr_ptr=0: order of grants is 0, then 1, then 2, then 0 again.
- Width rule: burst_cnt is clog2(MAX_BURST)+1 bits wide. The address compare is unsigned, at ADDR_W bits.

Decomposition:
- Shared package spu_pkg holds:
  - FB_WIDTH=320, FB_HEIGHT=240, FB_DEPTH=FB_WIDTH*FB_HEIGHT
  - FB_ADDR_W=17, PIXEL_W=24
  - requester index constants REQ_MAP=0, REQ_SPRITE=1, REQ_SCORE=2
  - FSM state encoding ST_IDLE, ST_GRANT
- One natural sub-module: rr_pick.
  - Combinational round-robin priority encoder.
  - Inputs: req vector and ptr. Outputs: any and idx.

Test Plan:
1. Single requester: map (0) bursts 4 beats at addrs 0,1,2,3 with data 24'h0000FF, last on beat 4.
   - Required: grant 1 cycle after valid; fb_we high for 4 consecutive cycles, each 1 cycle after its beat, with matching addr/data; busy drops after the last beat.
2. Simultaneous bursts: all three requesters present 2-beat bursts from reset.
   - Required: grant_id sequence 0,1,2 with one idle cycle between bursts; no req_ready overlap; 6 writes total.
3. Burst cap: sprite holds valid for 300 beats with last never asserted, MAX_BURST=256.
   - Required: released after exactly 256 writes; if score is waiting, the next grant goes to score.
4. Out of range: score writes addr 76799, then 76800, then 17'h1FFFF.
   - Required: only the first sets fb_we; oob_cnt=2; all three beats see req_ready handshakes.
5. Stall and reset: map deasserts valid for 3 cycles mid-burst.
   - Required: the grant is held, req_ready stays high, and there is no fb_we during the stall.
   - Then assert rst for 1 cycle: next cycle state is IDLE, fb_we=0, rr_ptr=0, oob_cnt=0.
6. Saturation: force 65540 out-of-range writes.
   - Required: oob_cnt stops at 16'hFFFF.
